data_sram_ctrl: RTL and testbench
=================================

# data_sram_ctrl

Responder end of the CPU data-memory port: it accepts the core's ce/we/addr/sel/data requests and drives an external 32-bit asynchronous SRAM with a fixed multi-cycle access. It returns read data with a one-cycle `ready_o` pulse, which the MEM stage waits on while stalling the pipeline. It sits at SoC level between the core's `ram_*` pins and the board SRAM. The bidirectional data bus is split into `dq_i`/`dq_o`/`dq_oe`; the tristate buffer lives in the top level.

## Interface
- `ADDR_W`, 20: SRAM word-address width.
- `WAIT_CYCLES`, 2: cycles spent in ACCESS; legal range 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `ce_i` in 1: request valid; held with all request fields until `ready_o` is seen.
- `we_i` in 1: 1 = write, 0 = read.
- `addr_i` in 32: byte address.
- `sel_i` in 4: byte enables; bit n = byte lane n.
- `data_i` in 32: write data.
- `data_o` out 32: read word, all four lanes. Byte extraction is done by the MEM stage.
- `ready_o` out 1: one-cycle completion pulse.
- `sram_addr_o` out ADDR_W: equals `addr_i[ADDR_W+1:2]`.
- `sram_dq_i` in 32: SRAM data in.
- `sram_dq_o` out 32: SRAM data out.
- `sram_dq_oe_o` out 1: top-level tristate enable.
- `sram_ce_n_o`, `sram_oe_n_o`, `sram_we_n_o` out 1 each: active-low strobes.
- `sram_be_n_o` out 4: active-low byte enables, equal to `~sel`.

## Operation
- **Reset values:** `ready_o` = 0; `data_o` = 0; `sram_addr_o` = 0; `sram_dq_o` = 0; `sram_dq_oe_o` = 0; `sram_ce_n_o`, `sram_oe_n_o`, `sram_we_n_o` = 1; `sram_be_n_o` = 4'hF. State = IDLE, counter = 0.
- **Request latching:** addr, we, sel and data are registered on the IDLE→SETUP edge. The SRAM is driven from these registers only, never combinationally from the core.
- **FSM states:**
  - IDLE: all strobes inactive. If `ce_i` = 1, go to SETUP.
  - SETUP: addr, be_n and ce_n valid. Read: `oe_n` = 0. Write: `dq_oe` = 1, `we_n` = 1. Counter loaded with WAIT_CYCLES. Go to ACCESS.
  - ACCESS: read keeps `oe_n` = 0; write holds `we_n` = 0 and `dq_oe` = 1. Counter decrements each cycle. On the cycle it reaches 1: a read captures `sram_dq_i` into `data_o`; then go to DONE.
  - DONE: `ready_o` = 1. `we_n` and `oe_n` = 1. `ce_n` and `dq_oe` stay asserted for write data hold. Go to IDLE unconditionally.
- **Why DONE returns to IDLE:** the core still presents the old request during DONE. The new request is first sampled in IDLE.
- **Abort:** if `ce_i` falls in SETUP or ACCESS (pipeline flush), go to IDLE on the next edge. No `ready_o` is raised, and `data_o` is not updated.
- **Write with `sel_i` = 0:** full handshake still runs with `be_n` = 4'hF; no SRAM byte changes.
- **Address bits:** `addr_i[1:0]` and `addr_i[31:ADDR_W+2]` are ignored, so upper address space aliases.
- **`data_o` hold:** holds its last captured value until the next completed read; unchanged by writes.

## Timing
- A request present in IDLE at cycle t gives SETUP at t+1, ACCESS at t+2 … t+1+WAIT_CYCLES, and `ready_o` at t+2+WAIT_CYCLES. With default WAIT_CYCLES = 2, `ready_o` is high in cycle t+4.
- `data_o` is valid in the `ready_o` cycle and afterwards.
- Back-to-back requests: minimum period is WAIT_CYCLES+3 cycles, because one IDLE cycle is mandatory.
- `we_n` low lasts exactly WAIT_CYCLES cycles. Address, data and be_n are stable one cycle before (SETUP) and one cycle after (DONE) the `we_n` low window.
- `rst` low asynchronously forces reset values at any state, including mid-write. Deassertion is synchronised by the top level.

## Structure
- Shared in `defines.v`:
  - state encodings `SramIdle`, `SramSetup`, `SramAccess`, `SramDone` as 2-bit macros;
  - the existing `RegBus` macro;
  - `SramAddrBus`.
- Single module, no sub-module; counter width is 4 bits.

## Test plan
- Reset mid-ACCESS of a write → same cycle: `we_n` = 1, `dq_oe` = 0, `ready_o` = 0, state IDLE.
- Write addr 0x0000_0010, sel 4'b0011, data 0xAABBCCDD; then read the same address, with the SRAM model preloaded to 0x11223344 →
  - write: `sram_addr_o` = 4, `be_n` = 4'b1100, `we_n` low for exactly 2 cycles;
  - read: `ready_o` in cycle t+4 with `data_o` = 0x1122CCDD.
- Two reads held back-to-back (ce high continuously, new address right after `ready_o`) → exactly one `ready_o` per request, 5-cycle spacing, and one IDLE cycle between them.
- `ce_i` dropped during ACCESS of a read → no `ready_o`, `data_o` unchanged, IDLE next cycle.
- Write with sel 0 → `be_n` = 4'hF throughout, `ready_o` after 4 cycles, memory unchanged; also run with WAIT_CYCLES = 1 → `ready_o` at t+3.

Source files
------------

// File: rtl/data_sram_ctrl_pkg.sv
// Shared types and constants for the CPU data-memory SRAM controller.
package data_sram_ctrl_pkg;

  // Width of the core-side data bus.
  localparam int REG_BUS_W = 32;
  // Number of byte lanes on the core-side data bus.
  localparam int SEL_W     = 4;
  // Width of the access-phase wait counter.
  localparam int CNT_W     = 4;

  // Access sequencer states.
  typedef enum logic [1:0] {
    SramIdle   = 2'd0,
    SramSetup  = 2'd1,
    SramAccess = 2'd2,
    SramDone   = 2'd3
  } sram_state_e;

endpackage

// File: rtl/data_sram_ctrl.sv
// Data-memory port responder: turns held core requests into a fixed-length
// asynchronous SRAM access and returns a one-cycle ready pulse with the word.
module data_sram_ctrl
  import data_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce_i,
  input  logic                 we_i,
  input  logic [REG_BUS_W-1:0] addr_i,
  input  logic [SEL_W-1:0]     sel_i,
  input  logic [REG_BUS_W-1:0] data_i,
  output logic [REG_BUS_W-1:0] data_o,
  output logic                 ready_o,
  output logic [ADDR_W-1:0]    sram_addr_o,
  input  logic [REG_BUS_W-1:0] sram_dq_i,
  output logic [REG_BUS_W-1:0] sram_dq_o,
  output logic                 sram_dq_oe_o,
  output logic                 sram_ce_n_o,
  output logic                 sram_oe_n_o,
  output logic                 sram_we_n_o,
  output logic [SEL_W-1:0]     sram_be_n_o
);

  // Counter reload value; WAIT_CYCLES is expected in 1..15.
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  sram_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;

  // Byte offset and high address bits are dropped: the upper space aliases.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[REG_BUS_W-1:ADDR_W+2], addr_i[1:0]};

  // Access sequencer; every SRAM pin is registered and driven from the
  // request copy taken on the IDLE->SETUP edge, never from the core directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= SramIdle;
      cnt          <= '0;
      we_q         <= 1'b0;
      data_o       <= '0;
      ready_o      <= 1'b0;
      sram_addr_o  <= '0;
      sram_dq_o    <= '0;
      sram_dq_oe_o <= 1'b0;
      sram_ce_n_o  <= 1'b1;
      sram_oe_n_o  <= 1'b1;
      sram_we_n_o  <= 1'b1;
      sram_be_n_o  <= '1;
    end else if ((state == SramSetup || state == SramAccess) && !ce_i) begin
      // Pipeline flush: release the SRAM without a ready pulse or capture.
      state        <= SramIdle;
      cnt          <= '0;
      ready_o      <= 1'b0;
      sram_dq_oe_o <= 1'b0;
      sram_ce_n_o  <= 1'b1;
      sram_oe_n_o  <= 1'b1;
      sram_we_n_o  <= 1'b1;
      sram_be_n_o  <= '1;
    end else begin
      case (state)
        SramIdle: begin
          ready_o <= 1'b0;
          if (ce_i) begin
            state        <= SramSetup;
            cnt          <= WAIT_LD;
            we_q         <= we_i;
            sram_addr_o  <= addr_i[ADDR_W+1:2];
            sram_dq_o    <= data_i;
            sram_be_n_o  <= ~sel_i;
            sram_ce_n_o  <= 1'b0;
            sram_oe_n_o  <= we_i;
            sram_dq_oe_o <= we_i;
          end
        end
        SramSetup: begin
          // Address, lanes and write data have settled for one cycle.
          state       <= SramAccess;
          sram_we_n_o <= ~we_q;
        end
        SramAccess: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state       <= SramDone;
            ready_o     <= 1'b1;
            sram_we_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            if (!we_q) begin
              data_o <= sram_dq_i;
            end
          end
        end
        SramDone: begin
          // Core still shows the finished request here; resample it in IDLE.
          state        <= SramIdle;
          ready_o      <= 1'b0;
          sram_dq_oe_o <= 1'b0;
          sram_ce_n_o  <= 1'b1;
          sram_oe_n_o  <= 1'b1;
          sram_we_n_o  <= 1'b1;
          sram_be_n_o  <= '1;
        end
        default: begin
          state <= SramIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Bench for data_sram_ctrl: two instances (WAIT_CYCLES 2 and 1), a byte-lane
// SRAM model per instance and a word-level reference memory.
module tb_data_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce, we;
  logic [31:0] addr, data;
  logic [3:0]  sel;
  int          dsel;

  logic        ce0, ce1;
  logic [31:0] data_o0, data_o1, sdq_i0, sdq_i1, sdq_o0, sdq_o1;
  logic        ready0, ready1, sdq_oe0, sdq_oe1;
  logic        ce_n0, ce_n1, oe_n0, oe_n1, we_n0, we_n1;
  logic [19:0] saddr0, saddr1;
  logic [3:0]  be_n0, be_n1;

  logic [31:0] o_data, o_dq;
  logic        o_ready, o_dq_oe, o_ce_n, o_oe_n, o_we_n;
  logic [19:0] o_addr;
  logic [3:0]  o_be_n;

  logic [31:0] smem [2][256];
  logic [31:0] rmem [2][256];
  logic [31:0] rdata [2];
  logic        pl_en;
  logic        pl_w;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ce0 = ce && (dsel == 0);
  assign ce1 = ce && (dsel == 1);

  data_sram_ctrl #(.ADDR_W(20), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .ce_i(ce0), .we_i(we), .addr_i(addr), .sel_i(sel),
    .data_i(data), .data_o(data_o0), .ready_o(ready0), .sram_addr_o(saddr0),
    .sram_dq_i(sdq_i0), .sram_dq_o(sdq_o0), .sram_dq_oe_o(sdq_oe0),
    .sram_ce_n_o(ce_n0), .sram_oe_n_o(oe_n0), .sram_we_n_o(we_n0),
    .sram_be_n_o(be_n0));

  data_sram_ctrl #(.ADDR_W(20), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .ce_i(ce1), .we_i(we), .addr_i(addr), .sel_i(sel),
    .data_i(data), .data_o(data_o1), .ready_o(ready1), .sram_addr_o(saddr1),
    .sram_dq_i(sdq_i1), .sram_dq_o(sdq_o1), .sram_dq_oe_o(sdq_oe1),
    .sram_ce_n_o(ce_n1), .sram_oe_n_o(oe_n1), .sram_we_n_o(we_n1),
    .sram_be_n_o(be_n1));

  assign o_data  = (dsel == 1) ? data_o1 : data_o0;
  assign o_ready = (dsel == 1) ? ready1  : ready0;
  assign o_addr  = (dsel == 1) ? saddr1  : saddr0;
  assign o_dq    = (dsel == 1) ? sdq_o1  : sdq_o0;
  assign o_dq_oe = (dsel == 1) ? sdq_oe1 : sdq_oe0;
  assign o_ce_n  = (dsel == 1) ? ce_n1   : ce_n0;
  assign o_oe_n  = (dsel == 1) ? oe_n1   : oe_n0;
  assign o_we_n  = (dsel == 1) ? we_n1   : we_n0;
  assign o_be_n  = (dsel == 1) ? be_n1   : be_n0;

  // Asynchronous SRAM: drives the bus while selected and output-enabled.
  assign sdq_i0 = (!ce_n0 && !oe_n0) ? smem[0][saddr0[7:0]] : 32'hDEAD_BEEF;
  assign sdq_i1 = (!ce_n1 && !oe_n1) ? smem[1][saddr1[7:0]] : 32'hDEAD_BEEF;

  // SRAM array update: bench preload, or enabled byte lanes while we_n is low.
  always @(negedge clk) begin
    if (pl_en) begin
      smem[pl_w][pl_idx] <= pl_val;
    end else begin
      if (!ce_n0 && !we_n0)
        for (int b = 0; b < 4; b++)
          if (!be_n0[b]) smem[0][saddr0[7:0]][8*b +: 8] <= sdq_o0[8*b +: 8];
      if (!ce_n1 && !we_n1)
        for (int b = 0; b < 4; b++)
          if (!be_n1[b]) smem[1][saddr1[7:0]][8*b +: 8] <= sdq_o1[8*b +: 8];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0]  s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic preload(input int w, input int idx, input logic [31:0] v);
    pl_w   = w[0];
    pl_idx = idx[7:0];
    pl_val = v;
    pl_en  = 1'b1;
    @(negedge clk);
    #1 pl_en = 1'b0;
    rmem[w][idx] = v;
  endtask

  // One complete request on the selected instance, checked against the model.
  task automatic do_req(input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input string tag);
    int n, we_low, ce_low, wc, idx;
    bit bus_ok;
    logic [31:0] t, exp_d;
    logic [19:0] exp_addr;
    wc = (dsel == 1) ? 1 : 2;
    t = (a >> 2) & 32'h000F_FFFF;
    exp_addr = t[19:0];
    idx = int'(t % 256);
    @(negedge clk);
    ce = 1'b1; we = w; addr = a; sel = s; data = d;
    n = 0; we_low = 0; ce_low = 0; bus_ok = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
      if (o_ce_n === 1'b0) begin
        ce_low++;
        if (o_addr !== exp_addr || o_be_n !== ~s) bus_ok = 1'b0;
        if (w && (o_dq_oe !== 1'b1 || o_dq !== d || o_oe_n !== 1'b1)) bus_ok = 1'b0;
        if (!w && (o_dq_oe !== 1'b0 || o_we_n !== 1'b1 || o_oe_n !== o_ready)) bus_ok = 1'b0;
      end
      if (o_we_n === 1'b0) we_low++;
    end while (o_ready !== 1'b1 && n < 20);
    ce = 1'b0;
    if (w) rmem[dsel][idx] = merge(rmem[dsel][idx], d, s);
    else   rdata[dsel] = rmem[dsel][idx];
    exp_d = rdata[dsel];

    checks++;
    if (o_ready !== 1'b1 || n !== 2 + wc) begin
      failures++;
      $display("FAIL %s ready_latency: got %0d cycles (ready=%b) expected %0d", tag, n, o_ready, 2 + wc);
    end
    checks++;
    if (bus_ok !== 1'b1) begin
      failures++;
      $display("FAIL %s sram_bus: addr/be_n/dq/strobes wrong, got addr=%h be_n=%b expected addr=%h be_n=%b",
               tag, o_addr, o_be_n, exp_addr, ~s);
    end
    checks++;
    if (we_low !== (w ? wc : 0) || ce_low !== wc + 2) begin
      failures++;
      $display("FAIL %s strobe_len: got we_n_low=%0d ce_n_low=%0d expected %0d and %0d",
               tag, we_low, ce_low, w ? wc : 0, wc + 2);
    end
    checks++;
    if (o_data !== exp_d) begin
      failures++;
      $display("FAIL %s data_o: got %h expected %h", tag, o_data, exp_d);
    end
    @(posedge clk); #1;
    checks++;
    if (o_ready !== 1'b0 || o_ce_n !== 1'b1 || o_we_n !== 1'b1 || o_oe_n !== 1'b1 || o_dq_oe !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_after: got ready=%b ce_n=%b we_n=%b oe_n=%b dq_oe=%b expected 0 1 1 1 0",
               tag, o_ready, o_ce_n, o_we_n, o_oe_n, o_dq_oe);
    end
    if (w) begin
      checks++;
      if (smem[dsel][idx] !== rmem[dsel][idx]) begin
        failures++;
        $display("FAIL %s sram_word: got %h expected %h", tag, smem[dsel][idx], rmem[dsel][idx]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 256; i++) preload(w, i, $urandom);
    rdata[0] = 32'h0;
    rdata[1] = 32'h0;
    checks++;
    if (ready0 !== 1'b0 || data_o0 !== 32'h0 || saddr0 !== 20'h0 || sdq_o0 !== 32'h0 || sdq_oe0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_data: got ready=%b data_o=%h addr=%h dq=%h dq_oe=%b expected all zero",
               ready0, data_o0, saddr0, sdq_o0, sdq_oe0);
    end
    checks++;
    if (ce_n0 !== 1'b1 || oe_n0 !== 1'b1 || we_n0 !== 1'b1 || be_n0 !== 4'hF || ready1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes: got ce_n=%b oe_n=%b we_n=%b be_n=%h ready1=%b expected 1 1 1 f 0",
               ce_n0, oe_n0, we_n0, be_n0, ready1);
    end
    @(negedge clk); rst = 1'b1;

    // Reset landing in the middle of a write access.
    dsel = 0;
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = 32'h0000_0020; sel = 4'hF; data = $urandom;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (we_n0 !== 1'b0) begin
      failures++;
      $display("FAIL midwrite_access: got we_n=%b expected 0", we_n0);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (we_n0 !== 1'b1 || sdq_oe0 !== 1'b0 || ready0 !== 1'b0 || ce_n0 !== 1'b1 || be_n0 !== 4'hF || saddr0 !== 20'h0) begin
      failures++;
      $display("FAIL midwrite_reset: got we_n=%b dq_oe=%b ready=%b ce_n=%b be_n=%h addr=%h expected 1 0 0 1 f 0",
               we_n0, sdq_oe0, ready0, ce_n0, be_n0, saddr0);
    end
    ce = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ce_n0 !== 1'b1 || ready0 !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: got ce_n=%b ready=%b expected 1 0", ce_n0, ready0);
    end
  endtask

  task automatic test_write_read();
    dsel = 0;
    preload(0, 4, 32'h1122_3344);
    do_req(1'b1, 32'h0000_0010, 4'b0011, 32'hAABB_CCDD, "wr_0x10");
    do_req(1'b0, 32'h0000_0010, 4'hF, $urandom, "rd_0x10");
    checks++;
    if (o_data !== 32'h1122_CCDD) begin
      failures++;
      $display("FAIL merged_read: got %h expected 1122ccdd", o_data);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, a;
    dsel = 0;
    for (int k = 0; k < 24; k++) begin
      r = $urandom;
      a = {r[31:22], 12'h000, 4'h0, r[5:2], r[1:0]};
      do_req(r[8], a, r[15:12], $urandom, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, a2, e1, e2;
    int start, c1, c2, nready, idle_cyc;
    dsel = 0;
    a1 = 32'h0000_0024;
    a2 = 32'hFFC0_0038;
    e1 = rmem[0][9];
    e2 = rmem[0][14];
    @(negedge clk);
    ce = 1'b1; we = 1'b0; sel = 4'hF; addr = a1; data = $urandom;
    start = cyc;
    c1 = -1; c2 = -1; nready = 0; idle_cyc = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (o_ready === 1'b1) begin
        nready++;
        if (c1 < 0) begin
          c1 = cyc;
          checks++;
          if (o_data !== e1) begin
            failures++;
            $display("FAIL b2b_data1: got %h expected %h", o_data, e1);
          end
          addr = a2;
        end else begin
          c2 = cyc;
          checks++;
          if (o_data !== e2) begin
            failures++;
            $display("FAIL b2b_data2: got %h expected %h", o_data, e2);
          end
          ce = 1'b0;
          break;
        end
      end else if (c1 >= 0 && o_ce_n === 1'b1) begin
        idle_cyc++;
      end
    end
    ce = 1'b0;
    rdata[0] = e2;
    checks++;
    if (nready !== 2 || c1 - start !== 4 || c2 - c1 !== 5 || idle_cyc !== 1) begin
      failures++;
      $display("FAIL b2b_timing: got readys=%0d first=%0d spacing=%0d idle=%0d expected 2 4 5 1",
               nready, c1 - start, c2 - c1, idle_cyc);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (o_ready !== 1'b0 || o_ce_n !== 1'b1) begin
      failures++;
      $display("FAIL b2b_no_third: got ready=%b ce_n=%b expected 0 1", o_ready, o_ce_n);
    end
  endtask

  task automatic test_abort();
    bit saw_ready;
    dsel = 0;
    preload(0, 7, ~rdata[0]);
    @(negedge clk);
    ce = 1'b1; we = 1'b0; sel = 4'hF; addr = 32'h0000_001C;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ce = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (o_ce_n !== 1'b1 || o_oe_n !== 1'b1 || o_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: got ce_n=%b oe_n=%b ready=%b expected 1 1 0", o_ce_n, o_oe_n, o_ready);
    end
    saw_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (o_ready !== 1'b0) saw_ready = 1'b1;
    end
    checks++;
    if (saw_ready !== 1'b0 || o_data !== rdata[0]) begin
      failures++;
      $display("FAIL abort_hold: got ready_seen=%b data_o=%h expected 0 %h", saw_ready, o_data, rdata[0]);
    end
  endtask

  task automatic test_sel_zero();
    dsel = 0;
    do_req(1'b1, 32'h0000_0030, 4'h0, $urandom, "sel0_w2");
    dsel = 1;
    do_req(1'b1, 32'h0000_0030, 4'h0, $urandom, "sel0_w1");
  endtask

  task automatic test_wait1();
    logic [31:0] r;
    dsel = 1;
    do_req(1'b1, 32'h0000_0010, 4'b1001, 32'h5566_7788, "w1_write");
    do_req(1'b0, 32'h0000_0010, 4'hF, 32'h0, "w1_read");
    for (int k = 0; k < 8; k++) begin
      r = $urandom;
      do_req(r[8], {r[31:22], 16'h0000, r[5:2], r[1:0]}, r[15:12], $urandom, "w1_random");
    end
    dsel = 0;
  endtask

  initial begin
    ce = 1'b0; we = 1'b0; addr = '0; sel = '0; data = '0; dsel = 0;
    pl_en = 1'b0; pl_w = 1'b0; pl_idx = '0; pl_val = '0;
    test_reset();
    test_write_read();
    test_random();
    test_back_to_back();
    test_abort();
    test_sel_zero();
    test_wait1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
